// File: rtl/accel_cfg_pkg.sv
// accel_cfg_pkg: config word widths shared with the accelerator top, loader FSM encoding, row width helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a. READBACK_EN adds the two readback states to the encoding.
package accel_cfg_pkg;

    localparam int DATA_CWIDTH = 32;
    localparam int WICP_CWIDTH = 32;
    localparam int TMPC_CWIDTH = 32;
    localparam int POST_CWIDTH = 32;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_FILL     = 3'd1;
    localparam logic [2:0] ST_WRITE    = 3'd2;
    localparam logic [2:0] ST_CFG_REQ  = 3'd3;
    localparam logic [2:0] ST_CFG_WAIT = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;
`ifdef READBACK_EN
    localparam logic [2:0] ST_RB_ISSUE = 3'd6;
    localparam logic [2:0] ST_RB_DRAIN = 3'd7;
`endif

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_FILL     = ST_FILL,
        S_WRITE    = ST_WRITE,
        S_CFG_REQ  = ST_CFG_REQ,
        S_CFG_WAIT = ST_CFG_WAIT,
        S_DONE     = ST_DONE
`ifdef READBACK_EN
        ,
        S_RB_ISSUE = ST_RB_ISSUE,
        S_RB_DRAIN = ST_RB_DRAIN
`endif
    } state_t;

    // Width of one outside_memory row in bits.
    function automatic int row_width(input int dw, input int lanes);
        return dw * lanes;
    endfunction

endpackage

// File: rtl/accel_cfg_loader_row_packer.sv
// row_packer: serial-to-parallel packer, word k of a row lands in lane k.
// Latency: a word is visible in row the cycle after it is accepted; row_full flags the last accept.
// Backpressure: none internally; accept is the caller's transfer strobe, clear restarts at lane 0.
module row_packer
    import accel_cfg_pkg::*;
#(
    parameter int DWIDTH = 16,
    parameter int PE_ROW = 12
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [DWIDTH-1:0]                    word,
    input  logic                                 accept,
    input  logic                                 clear,
    output logic [row_width(DWIDTH, PE_ROW)-1:0] row,
    output logic                                 row_full
);

    localparam int CW = (PE_ROW > 1) ? $clog2(PE_ROW) : 1;

    logic [CW-1:0] lane_q;

    assign row_full = accept && (lane_q == CW'(PE_ROW - 1));

    // Lane counter and row register; clear drops any partial row.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q <= '0;
            row    <= '0;
        end else if (clear) begin
            lane_q <= '0;
            row    <= '0;
        end else if (accept) begin
            row[int'(lane_q)*DWIDTH +: DWIDTH] <= word;
            lane_q <= row_full ? '0 : lane_q + CW'(1);
        end
    end

endmodule

// File: rtl/accel_cfg_loader.sv
// accel_cfg_loader: packs serial words into rows, writes them from base_addr upward, then one cfg handshake.
// Latency: >= PE_ROW+1 cycles per row; cfg_valid on first cfg_busy-low cycle; done 1 cycle after cfg_busy falls.
// Backpressure: src_ready only while filling (no skid); cfg request held off by cfg_busy. READBACK_EN adds rb_* readback.
module accel_cfg_loader
    import accel_cfg_pkg::*;
#(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 16,
    parameter int PE_ROW = 12
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [AWIDTH-1:0]                    base_addr,
    input  logic [AWIDTH-1:0]                    row_num,
    input  logic [DATA_CWIDTH-1:0]               cfg_data_in,
    input  logic [WICP_CWIDTH-1:0]               cfg_wicp_in,
    input  logic [TMPC_CWIDTH-1:0]               cfg_tmpc_in,
    input  logic [POST_CWIDTH-1:0]               cfg_post_in,
    input  logic                                 src_valid,
    output logic                                 src_ready,
    input  logic [DWIDTH-1:0]                    src_data,
    output logic                                 cfg_valid,
    input  logic                                 cfg_busy,
    output logic [DATA_CWIDTH-1:0]               cfg_data_data,
    output logic [WICP_CWIDTH-1:0]               cfg_wicp_data,
    output logic [TMPC_CWIDTH-1:0]               cfg_tmpc_data,
    output logic [POST_CWIDTH-1:0]               cfg_post_data,
    output logic [AWIDTH-1:0]                    outside_memory_addr,
    output logic                                 outside_memory_wreq,
    output logic [row_width(DWIDTH, PE_ROW)-1:0] outside_memory_din,
    input  logic [row_width(DWIDTH, PE_ROW)-1:0] outside_memory_dout,
    output logic                                 busy,
    output logic                                 done
`ifdef READBACK_EN
    ,
    output logic                                 rb_valid,
    output logic [row_width(DWIDTH, PE_ROW)-1:0] rb_data
`endif
);

    localparam int RW = row_width(DWIDTH, PE_ROW);

    state_t                 state_q, state_d;
    logic [AWIDTH-1:0]      base_q, rows_q, row_idx_q, addr_q;
    logic [DATA_CWIDTH-1:0] cfg_data_q;
    logic [WICP_CWIDTH-1:0] cfg_wicp_q;
    logic [TMPC_CWIDTH-1:0] cfg_tmpc_q;
    logic [POST_CWIDTH-1:0] cfg_post_q;
    logic                   seen_busy_q;
    logic                   accept, row_full, last_row, pk_clear;
    logic [RW-1:0]          row;

    assign src_ready = (state_q == S_FILL);
    assign accept    = src_valid && src_ready;
    // row_idx doubles as the readback index, so the same compare ends both loops.
    assign last_row  = (row_idx_q == rows_q - AWIDTH'(1));
    assign pk_clear  = ((state_q == S_IDLE) && start) || (state_q == S_WRITE);
    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);

    assign outside_memory_addr = addr_q;
    assign outside_memory_din  = outside_memory_wreq ? row : '0;
    assign cfg_data_data = cfg_data_q;
    assign cfg_wicp_data = cfg_wicp_q;
    assign cfg_tmpc_data = cfg_tmpc_q;
    assign cfg_post_data = cfg_post_q;

    row_packer #(
        .DWIDTH (DWIDTH),
        .PE_ROW (PE_ROW)
    ) u_row_packer (
        .clk      (clk),
        .rst_n    (rst_n),
        .word     (src_data),
        .accept   (accept),
        .clear    (pk_clear),
        .row      (row),
        .row_full (row_full)
    );

    // State register; reset abandons any job in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next state plus the one-cycle strobes (write request, cfg request).
    always_comb begin
        state_d             = state_q;
        cfg_valid           = 1'b0;
        outside_memory_wreq = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = (row_num != '0) ? S_FILL : S_CFG_REQ;
            end
            S_FILL: begin
                if (row_full) state_d = S_WRITE;
            end
            S_WRITE: begin
                outside_memory_wreq = 1'b1;
                state_d = last_row ? S_CFG_REQ : S_FILL;
            end
            S_CFG_REQ: begin
                if (!cfg_busy) begin
                    cfg_valid = 1'b1;
                    state_d   = S_CFG_WAIT;
                end
            end
            S_CFG_WAIT: begin
                // Only a fall after a rise counts as the accelerator finishing.
                if (seen_busy_q && !cfg_busy) begin
`ifdef READBACK_EN
                    state_d = (rows_q != '0) ? S_RB_ISSUE : S_DONE;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef READBACK_EN
            S_RB_ISSUE: begin
                if (last_row) state_d = S_RB_DRAIN;
            end
            S_RB_DRAIN: begin
                state_d = S_DONE;
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Job parameters captured at start, row/address counters and busy-rise tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q      <= '0;
            rows_q      <= '0;
            row_idx_q   <= '0;
            addr_q      <= '0;
            cfg_data_q  <= '0;
            cfg_wicp_q  <= '0;
            cfg_tmpc_q  <= '0;
            cfg_post_q  <= '0;
            seen_busy_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        base_q     <= base_addr;
                        rows_q     <= row_num;
                        cfg_data_q <= cfg_data_in;
                        cfg_wicp_q <= cfg_wicp_in;
                        cfg_tmpc_q <= cfg_tmpc_in;
                        cfg_post_q <= cfg_post_in;
                        row_idx_q  <= '0;
                    end
                end
                S_FILL: begin
                    // Address is loaded as the row completes so it is ready in WRITE.
                    if (row_full) addr_q <= base_q + row_idx_q;
                end
                S_WRITE: begin
                    if (!last_row) row_idx_q <= row_idx_q + AWIDTH'(1);
                end
                S_CFG_REQ: begin
                    seen_busy_q <= 1'b0;
                end
                S_CFG_WAIT: begin
                    if (cfg_busy) seen_busy_q <= 1'b1;
`ifdef READBACK_EN
                    if (seen_busy_q && !cfg_busy && (rows_q != '0)) begin
                        row_idx_q <= '0;
                        addr_q    <= base_q;
                    end
`endif
                end
`ifdef READBACK_EN
                S_RB_ISSUE: begin
                    if (!last_row) begin
                        row_idx_q <= row_idx_q + AWIDTH'(1);
                        addr_q    <= addr_q + AWIDTH'(1);
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

`ifdef READBACK_EN
    logic rb_valid_q;

    // Read data returns one cycle after each issued address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rb_valid_q <= 1'b0;
        else        rb_valid_q <= (state_q == S_RB_ISSUE);
    end

    assign rb_valid = rb_valid_q;
    assign rb_data  = rb_valid_q ? outside_memory_dout : '0;
`else
    logic [RW-1:0] unused_dout;
    assign unused_dout = outside_memory_dout;
`endif

endmodule
